btn_debounce: RTL and testbench
===============================

BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4, number of independent button channels.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (10 ms at 100 MHz), stable-input cycles required to accept a change; legal range >= 2.
REQ-003 The block SHALL have port clk  input  1  system clock, all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port btn_raw  input  N_BTN  raw, asynchronous, bouncing push-button levels, 1 = pressed.
REQ-006 The block SHALL have port btn_level  output  N_BTN  debounced button level per channel.
REQ-007 The block SHALL have port btn_pulse  output  N_BTN  one-clk pulse per accepted press; bit 0 drives the operand loader's btn_load.

Function
REQ-008 Each channel SHALL pass btn_raw through a 2-flop synchronizer; only the second flop output (sync) feeds the FSM.
REQ-009 Each channel SHALL implement FSM states IDLE, PRESS_CHK, HELD, REL_CHK with a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-010 IDLE: sync=1 -> PRESS_CHK with cnt=0; else stay.
REQ-011 PRESS_CHK: sync=0 -> IDLE, cnt cleared; sync=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD; else cnt+1.
REQ-012 HELD: sync=0 -> REL_CHK with cnt=0; else stay.
REQ-013 REL_CHK: sync=1 -> HELD, cnt cleared; sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
REQ-014 btn_level SHALL be a registered 1 while state is HELD or REL_CHK, and 0 otherwise.
REQ-015 btn_pulse SHALL be registered and high for exactly one clk, in the cycle after the PRESS_CHK->HELD transition edge, aligned with btn_level rising.
REQ-016 Latency: with btn_raw rising and then stable, btn_pulse and btn_level SHALL be high after clk edge DEBOUNCE_CYCLES+3, counting from the first edge that samples the new level.
REQ-017 Release SHALL produce no pulse; btn_level falls after edge DEBOUNCE_CYCLES+3 of a stable release.
REQ-018 Any bounce shorter than DEBOUNCE_CYCLES SHALL restart the check with no output change.
REQ-019 A held button SHALL produce exactly one pulse, with no auto-repeat.
REQ-020 Channels SHALL be fully independent; simultaneous presses SHALL give simultaneous pulses.
REQ-021 The counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.

Reset
REQ-022 rst SHALL asynchronously clear synchronizer flops, counters, btn_level and btn_pulse to 0, and all FSMs to IDLE.
REQ-023 rst asserted mid-check or mid-hold SHALL abort with no pulse.
REQ-024 After rst release with a button already held, the channel SHALL re-qualify and then emit one pulse (REQ-016 timing).

Structure
REQ-025 The FSM state typedef (deb_state_t) SHALL live in shared package alu_pkg.
REQ-026 Default DEBOUNCE_CYCLES SHALL live in alu_pkg as constant DEB_CYCLES_DEFAULT.
REQ-027 One sub-module debounce_ch SHALL implement the per-channel synchronizer, FSM, counter and outputs.
REQ-028 btn_debounce SHALL instantiate N_BTN copies of debounce_ch in a generate loop.

Verification (DEBOUNCE_CYCLES=4, N_BTN=4)
REQ-029 Clean press: btn_raw[0] 0->1 held 20 cycles -> btn_pulse[0] high exactly 1 cycle, after edge 7; btn_level[0]=1 from the same cycle.
REQ-030 Bounce: btn_raw[0] toggles 1,0,1,0 one cycle each, then 1 stable -> single pulse, 7 edges after the final rise; none earlier.
REQ-031 Glitch: btn_raw[1]=1 for 3 cycles, then 0 -> btn_pulse[1] and btn_level[1] stay 0.
REQ-032 Release: after a held press, btn_raw[0]=0 stable -> btn_level[0] falls after edge 7 with no pulse; a 2-cycle release glitch leaves btn_level[0]=1.
REQ-033 Reset mid-check: rst pulsed while in PRESS_CHK with btn_raw[2] held -> outputs 0 immediately, then one pulse 7 edges after rst release.
REQ-034 Simultaneous: btn_raw=4'b1111 at one edge -> btn_pulse=4'b1111 for 1 cycle, then 4'b0000 while held.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the operand-entry front end.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } deb_state_t;

    // 10 ms of stability at a 100 MHz system clock
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one button channel - 2-flop synchronizer, press/release qualifier FSM,
// registered level and single-cycle press pulse.
module debounce_ch
    import alu_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic meta, sync;
    logic [CW-1:0] cnt, next_cnt;
    deb_state_t state, next_state;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            state <= next_state;
            cnt   <= next_cnt;
            level <= (next_state == HELD) || (next_state == REL_CHK);
            pulse <= (state == PRESS_CHK) && (next_state == HELD);
        end

    // Counter saturates at LAST by leaving the check state; it never wraps.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE:
                if (sync) begin
                    next_state = PRESS_CHK;
                    next_cnt   = '0;
                end
            PRESS_CHK:
                if (!sync) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (cnt == LAST) begin
                    next_state = HELD;
                    next_cnt   = '0;
                end else
                    next_cnt = cnt + 1'b1;
            HELD:
                if (!sync) begin
                    next_state = REL_CHK;
                    next_cnt   = '0;
                end
            REL_CHK:
                if (sync) begin
                    next_state = HELD;
                    next_cnt   = '0;
                end else if (cnt == LAST) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else
                    next_cnt = cnt + 1'b1;
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: N_BTN independent push-button debouncers; btn_pulse[0] feeds the
// operand loader's btn_load.
module btn_debounce
    import alu_pkg::*;
#(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .pulse(btn_pulse[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed checks of press latency, bounce, glitch, release, reset and
// simultaneous presses with DEBOUNCE_CYCLES=4.
module tb_btn_debounce;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] btn_level, btn_pulse;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    btn_debounce #(
        .N_BTN(4),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #1;
        chk("reset_level", btn_level, 4'b0000);
        chk("reset_pulse", btn_pulse, 4'b0000);
        tick(2);
        rst = 1'b0;

        // clean press on channel 0: pulse exactly after edge 7
        btn_raw = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("press_early_pulse", btn_pulse, 4'b0000);
            chk("press_early_level", btn_level, 4'b0000);
        end
        tick(1);
        chk("press_pulse", btn_pulse, 4'b0001);
        chk("press_level", btn_level, 4'b0001);
        for (int i = 0; i < 13; i++) begin
            tick(1);
            chk("hold_no_repeat", btn_pulse, 4'b0000);
            chk("hold_level", btn_level, 4'b0001);
        end

        // 2-cycle release glitch keeps the level
        btn_raw = 4'b0000;
        tick(2);
        btn_raw = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("rel_glitch_level", btn_level, 4'b0001);
            chk("rel_glitch_pulse", btn_pulse, 4'b0000);
        end

        // stable release: level falls after edge 7, no pulse
        btn_raw = 4'b0000;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("release_early_level", btn_level, 4'b0001);
            chk("release_pulse", btn_pulse, 4'b0000);
        end
        tick(1);
        chk("release_level", btn_level, 4'b0000);
        chk("release_pulse7", btn_pulse, 4'b0000);
        tick(4);

        // bounce 1,0,1,0 then stable 1
        for (int i = 0; i < 4; i++) begin
            btn_raw = (i % 2 == 0) ? 4'b0001 : 4'b0000;
            tick(1);
            chk("bounce_pulse", btn_pulse, 4'b0000);
        end
        btn_raw = 4'b0001;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("bounce_early_pulse", btn_pulse, 4'b0000);
            chk("bounce_early_level", btn_level, 4'b0000);
        end
        tick(1);
        chk("bounce_pulse7", btn_pulse, 4'b0001);
        tick(1);
        chk("bounce_single", btn_pulse, 4'b0000);
        btn_raw = 4'b0000;
        tick(10);
        chk("bounce_released", btn_level, 4'b0000);

        // 3-cycle glitch on channel 1 is rejected
        btn_raw = 4'b0010;
        tick(3);
        btn_raw = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("glitch_pulse", btn_pulse, 4'b0000);
            chk("glitch_level", btn_level, 4'b0000);
        end

        // channel 3 held, channel 2 mid-check when reset hits
        btn_raw = 4'b1000;
        tick(7);
        chk("ch3_pulse", btn_pulse, 4'b1000);
        tick(2);
        chk("ch3_level", btn_level, 4'b1000);
        btn_raw = 4'b1100;
        tick(4);
        rst = 1'b1;
        #1;
        chk("rst_async_level", btn_level, 4'b0000);
        chk("rst_async_pulse", btn_pulse, 4'b0000);
        tick(2);
        chk("rst_hold_level", btn_level, 4'b0000);
        rst = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk("rst_requal_early", btn_pulse, 4'b0000);
        end
        tick(1);
        chk("rst_requal_pulse", btn_pulse, 4'b1100);
        chk("rst_requal_level", btn_level, 4'b1100);
        tick(1);
        chk("rst_requal_single", btn_pulse, 4'b0000);
        btn_raw = 4'b0000;
        tick(10);
        chk("rst_requal_released", btn_level, 4'b0000);

        // simultaneous presses on all channels
        btn_raw = 4'b1111;
        tick(6);
        chk("simul_early", btn_pulse, 4'b0000);
        tick(1);
        chk("simul_pulse", btn_pulse, 4'b1111);
        chk("simul_level", btn_level, 4'b1111);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("simul_held_pulse", btn_pulse, 4'b0000);
            chk("simul_held_level", btn_level, 4'b1111);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
